// File: rtl/a2d_intf.sv
// a2d_intf: A2D converter sequencer in front of a 16-bit SPI master.
// Each conversion is two SPI transactions: the first sends the channel
// command (response discarded), and the second clocks back the 12-bit
// result. A conversion starts either from a manual request (strt_cnv/chnnl)
// or from a round-robin scan while scan_en is high. Results are reported on
// a one-cycle cnv_cmplt pulse and are also kept in a per-channel table.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   strt_cnv, chnnl  manual conversion request (sampled only when idle)
//   scan_en          level; convert channels round-robin whenever idle
//   cnv_cmplt        one-cycle pulse: res/res_ch valid
//   res, res_ch      most recent result and its channel
//   busy             conversion in progress
//   rd_ch, rd_res    combinational read port of the result table
//   wrt, cmd         SPI master start pulse and transaction word
//   done, rd_data    SPI master completion pulse and received word
module a2d_intf #(
    parameter int unsigned NUM_CH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    input  logic        scan_en,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic [2:0]  res_ch,
    output logic        busy,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_res,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data
);

    typedef enum logic [2:0] {
        StIdle,
        StSend1,
        StWait1,
        StGap,
        StSend2,
        StWait2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cur_ch_q;
    logic        is_scan_q;
    logic [2:0]  scan_ptr_q;
    logic [11:0] res_q;
    logic [2:0]  res_ch_q;
    logic        cnv_cmplt_q;
    logic [15:0] cmd_q;
    logic [11:0] res_tbl_q [NUM_CH];

    logic        start;
    logic        start_scan;
    logic [2:0]  start_ch;
    logic        finish;

    // Upper nibble of the returned word carries no data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        start_scan = 1'b0;
        start_ch   = chnnl;
        finish     = 1'b0;
        wrt        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Manual request wins over scan in the same cycle.
                if (strt_cnv) begin
                    start    = 1'b1;
                    start_ch = chnnl;
                end else if (scan_en) begin
                    start      = 1'b1;
                    start_scan = 1'b1;
                    start_ch   = scan_ptr_q;
                end
                if (start) state_d = StSend1;
            end
            StSend1: begin
                wrt     = 1'b1;
                state_d = StWait1;
            end
            StWait1: if (done) state_d = StGap;
            // Converter turnaround between command and readback.
            StGap:   state_d = StSend2;
            StSend2: begin
                wrt     = 1'b1;
                state_d = StWait2;
            end
            StWait2: begin
                if (done) begin
                    finish  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_ch_q    <= 3'd0;
            is_scan_q   <= 1'b0;
            scan_ptr_q  <= 3'd0;
            res_q       <= 12'h000;
            res_ch_q    <= 3'd0;
            cnv_cmplt_q <= 1'b0;
            cmd_q       <= 16'h0000;
            for (int unsigned i = 0; i < NUM_CH; i++) res_tbl_q[i] <= 12'h000;
        end else begin
            state_q     <= state_d;
            cnv_cmplt_q <= finish;
            if (start) begin
                cur_ch_q  <= start_ch;
                is_scan_q <= start_scan;
                cmd_q     <= {2'b00, start_ch, 11'h000};
            end
            if (finish) begin
                res_q    <= rd_data[11:0];
                res_ch_q <= cur_ch_q;
                // Out-of-range manual channels are reported but not stored.
                if (32'(cur_ch_q) < NUM_CH) res_tbl_q[cur_ch_q] <= rd_data[11:0];
                if (is_scan_q) begin
                    scan_ptr_q <= (32'(scan_ptr_q) == NUM_CH - 1) ? 3'd0 : scan_ptr_q + 3'd1;
                end
            end
        end
    end

    assign cnv_cmplt = cnv_cmplt_q;
    assign res       = res_q;
    assign res_ch    = res_ch_q;
    assign busy      = (state_q != StIdle);
    assign cmd       = cmd_q;
    assign rd_res    = (32'(rd_ch) < NUM_CH) ? res_tbl_q[rd_ch] : 12'h000;

endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboard bench for a2d_intf: stimulus pushes expected {channel, result}
// entries; a monitor pops and compares on every cnv_cmplt. A small SPI
// master model answers wrt pulses with done after a fixed latency.
module tb_a2d_intf;

    localparam int unsigned NUM_CH = 8;
    localparam int SPI_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        scan_en = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [2:0]  res_ch;
    logic        busy;
    logic [2:0]  rd_ch = 3'd0;
    logic [11:0] rd_res;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic        done_m = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] rd_data = 16'h0000;

    assign done = done_m | spur_done;

    a2d_intf #(.NUM_CH(NUM_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .strt_cnv (strt_cnv),
        .chnnl    (chnnl),
        .scan_en  (scan_en),
        .cnv_cmplt(cnv_cmplt),
        .res      (res),
        .res_ch   (res_ch),
        .busy     (busy),
        .rd_ch    (rd_ch),
        .rd_res   (rd_res),
        .wrt      (wrt),
        .cmd      (cmd),
        .done     (done),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] res;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] resp_tbl [8];
    logic [15:0] cmd1 = 16'h0;
    logic [15:0] cmd2 = 16'h0;
    int          gap_cycles = 0;
    int          done_cyc = 0;
    int          wrt_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endfunction

    function automatic void push_exp(input logic [2:0] ch, input logic [11:0] r);
        exp_t e;
        e.ch  = ch;
        e.res = r;
        exp_q.push_back(e);
    endfunction

    // SPI master model: first transaction returns junk, second returns resp_tbl[ch].
    initial begin : spi_model
        int unsigned n_xfer;
        logic [15:0] xcmd;
        n_xfer = 0;
        forever begin
            @(negedge clk);
            if (wrt === 1'b1) begin
                xcmd = cmd;
                if (n_xfer == 0) begin
                    cmd1 = cmd;
                end else begin
                    cmd2       = cmd;
                    gap_cycles = cyc - done_cyc;
                end
                repeat (SPI_LAT) @(posedge clk);
                #1;
                done_m   = 1'b1;
                rd_data  = (n_xfer == 0) ? 16'hDEAD : resp_tbl[xcmd[13:11]];
                done_cyc = cyc;
                n_xfer   = 1 - n_xfer;
                @(posedge clk);
                #1;
                done_m  = 1'b0;
                rd_data = 16'h0000;
            end
        end
    end

    // Monitor: wrt spacing and scoreboard compare on each completion.
    initial begin : monitor
        logic wrt_prev;
        exp_t e;
        wrt_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wrt === 1'b1) begin
                wrt_cnt++;
                chk("wrt_back_to_back", 32'(wrt_prev), 32'd0);
            end
            wrt_prev = wrt;
            if (cnv_cmplt === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cnv_cmplt", 32'(cnv_cmplt), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res", 32'(res), 32'(e.res));
                    chk("res_ch", 32'(res_ch), 32'(e.ch));
                    chk("cmd_first", 32'(cmd1), 32'({2'b00, e.ch, 11'h000}));
                    chk("cmd_second", 32'(cmd2), 32'({2'b00, e.ch, 11'h000}));
                    chk("gap_done_to_wrt2", 32'(gap_cycles), 32'd2);
                    chk("cmplt_after_done2", 32'(cyc - done_cyc), 32'd1);
                    chk("busy_at_cmplt", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic wait_wrt(input string nm);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wrt === 1'b1) return;
        end
        chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_cmplts(input int n);
        for (int k = 0; k < n; k++) begin
            int got;
            got = 0;
            for (int i = 0; i < 200 && got == 0; i++) begin
                @(negedge clk);
                if (cnv_cmplt === 1'b1) got = 1;
            end
            if (got == 0) begin
                chk("cnv_cmplt_timeout", 32'd1, 32'd0);
                return;
            end
        end
    endtask

    task automatic manual(input logic [2:0] ch);
        @(posedge clk);
        #1;
        strt_cnv = 1'b1;
        chnnl    = ch;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
    endtask

    task automatic check_rd(input string nm, input logic [2:0] ch, input logic [11:0] req);
        @(posedge clk);
        #1;
        rd_ch = ch;
        @(negedge clk);
        chk(nm, 32'(rd_res), 32'(req));
    endtask

    initial begin
        for (int n = 0; n < 8; n++) resp_tbl[n] = 16'h0000;
        resp_tbl[5] = 16'hFABC;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wrt", 32'(wrt), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'h0000);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_cnv_cmplt", 32'(cnv_cmplt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        for (int n = 0; n < 8; n++) check_rd("rst_table", 3'(n), 12'h000);

        // Manual conversion on channel 5.
        push_exp(3'd5, 12'hABC);
        manual(3'd5);
        wait_cmplts(1);
        check_rd("table_ch5_manual", 3'd5, 12'hABC);

        // Scan: 14 conversions, channels 0..7,0..5, leaving scan_ptr at 6.
        for (int n = 0; n < 8; n++) resp_tbl[n] = 16'h0100 + 16'(n);
        for (int i = 0; i < 14; i++) push_exp(3'(i % 8), 12'h100 + 12'(i % 8));
        @(posedge clk);
        #1;
        scan_en = 1'b1;
        wait_cmplts(13);
        @(posedge clk);
        #1;
        scan_en = 1'b0;
        wait_cmplts(1);
        for (int n = 0; n < 8; n++) check_rd("table_scan", 3'(n), 12'h100 + 12'(n));

        // Manual ch 3 and scan together: ch 3 first, then scan ch 6.
        resp_tbl[3] = 16'h5333;
        push_exp(3'd3, 12'h333);
        push_exp(3'd6, 12'h106);
        @(posedge clk);
        #1;
        strt_cnv = 1'b1;
        chnnl    = 3'd3;
        scan_en  = 1'b1;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        wait_cmplts(1);
        @(posedge clk);
        #1;
        scan_en = 1'b0;
        wait_cmplts(1);
        check_rd("table_ch3_manual", 3'd3, 12'h333);

        // strt_cnv during WAIT1 dropped; spurious done during GAP ignored.
        resp_tbl[2] = 16'h0102;
        push_exp(3'd2, 12'h102);
        manual(3'd2);
        wait_wrt("first_wrt");
        @(posedge clk);
        #1;
        strt_cnv = 1'b1;
        chnnl    = 3'd7;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        for (int i = 0; i < 20 && done_m !== 1'b1; i++) @(negedge clk);
        @(posedge clk);
        #1;
        spur_done = 1'b1;
        @(posedge clk);
        #1;
        spur_done = 1'b0;
        wait_cmplts(1);
        repeat (6) @(negedge clk);

        // Reset in WAIT2, late done afterwards, then a normal conversion.
        resp_tbl[1] = 16'h0111;
        manual(3'd1);
        wait_wrt("abort_wrt1");
        wait_wrt("abort_wrt2");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wrt", 32'(wrt), 32'd0);
        chk("midrst_cmd", 32'(cmd), 32'h0000);
        chk("midrst_res", 32'(res), 32'd0);
        chk("midrst_res_ch", 32'(res_ch), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cnv_cmplt", 32'(cnv_cmplt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 8; n++) check_rd("midrst_table", 3'(n), 12'h000);
        chk("late_done_res", 32'(res), 32'd0);
        chk("late_done_busy", 32'(busy), 32'd0);
        push_exp(3'd4, 12'h104);
        manual(3'd4);
        wait_cmplts(1);
        check_rd("table_ch4_after_rst", 3'd4, 12'h104);
        check_rd("table_ch5_after_rst", 3'd5, 12'h000);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("wrt_pulse_count", 32'(wrt_cnt), 32'd40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a2d_intf.md
# a2d_intf

Sequencer that sits directly upstream of the 16-bit SPI master and owns the A2D converter protocol. It turns a single-channel conversion request, or a continuous round-robin scan, into the required pair of SPI transactions. The first transaction sends the channel command; the second clocks back the 12-bit result. Results are returned on a handshake and kept in a per-channel result table for downstream consumers.

## Interface
Parameters:
- NUM_CH, 8 — channels in the scan (1..8); scan wraps from NUM_CH-1 to 0.

Ports:
- clk  in  1  system clock; all flops rise-edge.
- rst  in  1  asynchronous, active-high reset.
- strt_cnv  in  1  request one conversion on chnnl; sampled only in IDLE.
- chnnl  in  3  channel for strt_cnv request.
- scan_en  in  1  level; while high, block converts channels round-robin whenever idle.
- cnv_cmplt  out  1  one-cycle pulse: res/res_ch valid (manual or scan).
- res  out  12  most recent conversion result, held until next completion.
- res_ch  out  3  channel that res belongs to.
- busy  out  1  high from the cycle after a conversion starts through the cycle of its second done.
- rd_ch  in  3  table read address.
- rd_res  out  12  combinational table read: last result stored for rd_ch.
- wrt  out  1  to SPI master: one-cycle start pulse.
- cmd  out  16  to SPI master: transaction word.
- done  in  1  from SPI master: one-cycle transaction-complete pulse.
- rd_data  in  16  from SPI master: word shifted in, valid when done high.

## Operation
- States: IDLE, SEND1, WAIT1, GAP, SEND2, WAIT2.
- IDLE: on strt_cnv=1, latch chnnl into cur_ch, go SEND1. Otherwise, if scan_en=1, latch scan_ptr into cur_ch, go SEND1. Manual request has priority over scan in the same cycle.
- SEND1: wrt=1 for this one cycle; go WAIT1.
- WAIT1: wait for done; on done go GAP. rd_data from the first transaction is discarded.
- GAP: one dead cycle (converter turnaround); go SEND2.
- SEND2: wrt=1 for one cycle; go WAIT2.
- WAIT2: on done, perform all of the following, then go IDLE:
  - capture rd_data[11:0] into res;
  - set res_ch to cur_ch;
  - write rd_data[11:0] to table[cur_ch] if cur_ch < NUM_CH;
  - if the conversion was a scan conversion, advance scan_ptr.
- cmd = {2'b00, cur_ch, 11'h000} for both transactions; cmd is registered and stable from SEND1 through WAIT2.
- rd_data[15:12] is ignored.
- Manual channel >= NUM_CH: converted and reported on res, not written to the table.
- done seen in IDLE, SEND1, SEND2 or GAP is ignored.
- strt_cnv while busy is dropped, not queued.
- scan_en dropping mid-conversion: the current conversion completes and reports normally; no new scan conversion starts.
- scan_ptr increments modulo NUM_CH and advances only on scan-conversion completion.
- rst (any time, including mid-transaction): state to IDLE; wrt, cnv_cmplt and busy to 0; res, res_ch, cmd and scan_ptr to 0; all table entries to 0.

## Timing
- Request sampled at edge k (state IDLE) gives SEND1 in cycle k+1 (wrt=1, busy=1, cmd valid).
- First done high in cycle d gives GAP in d+1 and SEND2 with wrt=1 in d+2.
- Second done high in cycle e: res, res_ch and table update at the end of e; cnv_cmplt=1 in e+1 only; busy=0 from e+1.
- Back-to-back scan: IDLE in e+1, next wrt in e+2. Minimum overhead is 4 cycles per conversion beyond the two SPI transactions.
- rd_res reflects a table write in the cycle after that write (no bypass).
- wrt is never high for two consecutive cycles.

## Test plan
- Reset then idle: rst pulse → wrt=0, cmd=16'h0000, res=0, cnv_cmplt=0, rd_res=0 for every rd_ch.
- Manual ch 5, SPI model returns 16'hFABC on the 2nd transaction:
  - cmd=16'h2800 on both wrt pulses;
  - second wrt exactly 2 cycles after first done;
  - cnv_cmplt one cycle later with res=12'hABC, res_ch=5;
  - rd_res(rd_ch=5)=12'hABC.
- Scan with NUM_CH=8, model returns 16'h0100+ch for ch 0..7, run 9 conversions:
  - channels visited 0,1,…,7,0;
  - table[n]=12'h100+n;
  - wrap to 0 after 7.
- Simultaneous strt_cnv (chnnl=3) and scan_en=1 in IDLE with scan_ptr=6: ch 3 converts first, then ch 6; scan_ptr unchanged by the manual conversion.
- strt_cnv asserted during WAIT1 and spurious done during GAP: request ignored, no extra wrt, sequence timing unchanged.
- rst asserted during WAIT2, then a late done: everything returns to reset values, no cnv_cmplt, the late done is ignored, and a new strt_cnv works normally.
